// File: rtl/demux_1x16.sv
// Registered 1-to-N demultiplexer (default 1-to-16).
// Routes the DATA_W-bit input to the output lane chosen by sel; every other
// lane is driven to zero. Outputs are registered, so there is exactly one
// cycle of latency and no combinational path from inputs to outputs.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous reset, active-high (takes priority over en)
//   en       update enable; 0 holds o and sel_err
//   in       data to route
//   sel      destination lane index
//   o        N_OUT lanes; lane k = o[k*DATA_W +: DATA_W]
//   sel_err  set when the last captured sel addressed a non-existent lane
module demux_1x16 #(
  parameter int unsigned DATA_W = 1,
  parameter int unsigned N_OUT  = 16,
  parameter int unsigned SEL_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [DATA_W-1:0]       in,
  input  logic [SEL_W-1:0]        sel,
  output logic [N_OUT*DATA_W-1:0] o,
  output logic                    sel_err
);

  logic [N_OUT*DATA_W-1:0] o_d, o_q;
  logic                    sel_err_d, sel_err_q;

  // An enabled update rebuilds all lanes from zero, so the previously
  // selected lane is cleared on the same edge the new one is loaded. A sel
  // that matches no lane leaves everything zero and raises sel_err.
  always_comb begin
    o_d       = o_q;
    sel_err_d = sel_err_q;
    if (en) begin
      o_d       = '0;
      sel_err_d = 1'b1;
      for (int unsigned k = 0; k < N_OUT; k++) begin
        if (sel == SEL_W'(k)) begin
          o_d[k*DATA_W +: DATA_W] = in;
          sel_err_d               = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_q       <= '0;
      sel_err_q <= 1'b0;
    end else begin
      o_q       <= o_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign o       = o_q;
  assign sel_err = sel_err_q;

endmodule

// File: tb/tb_demux_1x16.sv
module tb_demux_1x16;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, in;
  logic [3:0]  sel;
  logic [15:0] o16;
  logic        e16;
  logic [9:0]  o10;
  logic        e10;

  int checks = 0;
  int errors = 0;

  // Reference state: what each lane set should hold after the last edge.
  logic [15:0] m16   = '0;
  logic        m_e16 = 1'b0;
  logic [9:0]  m10   = '0;
  logic        m_e10 = 1'b0;
  bit          model_valid = 1'b0;

  demux_1x16 #(.DATA_W(1), .N_OUT(16), .SEL_W(4)) dut16 (
    .clk(clk), .rst(rst), .en(en), .in(in), .sel(sel), .o(o16), .sel_err(e16)
  );

  demux_1x16 #(.DATA_W(1), .N_OUT(10), .SEL_W(4)) dut10 (
    .clk(clk), .rst(rst), .en(en), .in(in), .sel(sel), .o(o10), .sel_err(e10)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "/o16"}, o16, m16);
    check({tag, "/err16"}, {15'b0, e16}, {15'b0, m_e16});
    check({tag, "/o10"}, {6'b0, o10}, {6'b0, m10});
    check({tag, "/err10"}, {15'b0, e10}, {15'b0, m_e10});
  endtask

  // One clock: drive at negedge, confirm outputs have not moved before the
  // edge, then advance the model and compare just after the edge.
  task automatic step(input logic r, input logic e, input logic i, input logic [3:0] s,
                      input string tag);
    @(negedge clk);
    rst = r; en = e; in = i; sel = s;
    #1;
    if (model_valid) check_all({tag, "/pre"});
    @(posedge clk);
    if (r) begin
      m16 = '0; m_e16 = 1'b0; m10 = '0; m_e10 = 1'b0;
    end else if (e) begin
      m16   = 16'(i) << s;
      m_e16 = 1'b0;
      if (s < 4'd10) begin
        m10   = 10'(i) << s;
        m_e10 = 1'b0;
      end else begin
        m10   = '0;
        m_e10 = 1'b1;
      end
    end
    model_valid = 1'b1;
    #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; in = 1'b0; sel = '0;

    // Reset state
    step(1'b1, 1'b0, 1'b0, 4'd0, "reset");
    check("reset_lit", o16, 16'h0000);

    // 1: walking one across all lanes
    for (int s = 0; s < 16; s++) step(1'b0, 1'b1, 1'b1, 4'(s), "sweep1");
    step(1'b0, 1'b1, 1'b1, 4'd5, "sel5");
    check("sel5_lit", o16, 16'h0020);

    // 2: in=0 sweep keeps every lane zero
    for (int s = 0; s < 16; s++) step(1'b0, 1'b1, 1'b0, 4'(s), "sweep0");

    // 3: hold with en=0
    step(1'b0, 1'b1, 1'b1, 4'd9, "load9");
    for (int n = 0; n < 4; n++) begin
      step(1'b0, 1'b0, 1'b1, 4'd3, "hold");
      check("hold_lit", o16, 16'h0200);
    end

    // 4: mid-stream reset
    step(1'b0, 1'b1, 1'b1, 4'd7, "pre_rst");
    step(1'b1, 1'b1, 1'b1, 4'd7, "mid_rst");
    check("mid_rst_lit", o16, 16'h0000);
    step(1'b0, 1'b1, 1'b1, 4'd7, "post_rst");
    check("post_rst_lit", o16, 16'h0080);

    // 5: reset wins over enable
    step(1'b1, 1'b1, 1'b1, 4'd2, "rst_vs_en");
    check("rst_vs_en_lit", o16, 16'h0000);

    // 6: out-of-range select on the 10-lane instance
    step(1'b0, 1'b1, 1'b1, 4'd12, "oor");
    check("oor_o10", {6'b0, o10}, 16'h0000);
    check("oor_err10", {15'b0, e10}, 16'h0001);
    step(1'b0, 1'b1, 1'b1, 4'd4, "back_in");
    check("back_in_o10", {6'b0, o10}, 16'h0010);
    check("back_in_err10", {15'b0, e10}, 16'h0000);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      step(($urandom_range(15) == 0), ($urandom_range(3) != 0), 1'($urandom),
           4'($urandom), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
